priority_event_queue: RTL and testbench
=======================================

# priority_event_queue

Sequential stage directly downstream of the 16-to-4 priority encoder (`encoder16_4`). Samples the encoder's code `L[3:0]` and group-select `GS` every cycle. Debounces press and release, then emits exactly one event per press into a small FIFO with a valid/ready output handshake. Events are kept until the consumer (CPU-side register or display logic) takes them.

## Interface
Parameters:
- `CODE_W`, 4, width of the encoded index
- `DEBOUNCE`, 4, consecutive identical samples needed to accept a press or release; legal range 1..255
- `DEPTH`, 4, FIFO entries; power of two, at least 2

Ports:
- `clk`  in  1  single clock; all logic on its rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `en`  in  1  detector enable
- `code`  in  CODE_W  encoder `L` output
- `gs`  in  1  encoder `GS` output; high means a request is present
- `out_code`  out  CODE_W  code at the FIFO head
- `out_valid`  out  1  FIFO not empty
- `out_ready`  in  1  consumer accepts the head
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy
- `overflow`  out  1  sticky; set when an event is dropped
- `ovf_clr`  in  1  clears `overflow`

## Operation
- Detector FSM states: IDLE, PRESS, HELD, RELEASE. It uses a candidate register `cand` and a counter `cnt` (8 bits).
- IDLE:
  - `gs`=1 → PRESS, with `cand`←`code` and `cnt`←0.
- PRESS:
  - `gs`=0 → IDLE.
  - `gs`=1 and `code`≠`cand` → stay in PRESS, with `cand`←`code` and `cnt`←0 (restart).
  - Matching sample with `cnt`=DEBOUNCE-1 → push `cand` into the FIFO and go to HELD.
  - Any other matching sample → `cnt`+1.
- HELD:
  - `gs`=0 → RELEASE, with `cnt`←0.
  - A change of `code` while `gs`=1 is ignored. There is no second event until release.
- RELEASE:
  - `gs`=1 → HELD.
  - `gs`=0 with `cnt`=DEBOUNCE-1 → IDLE.
  - Otherwise `cnt`+1.
- `en`=0 forces the FSM to IDLE with `cnt`←0 on every edge. The FIFO contents and the output handshake are unaffected.
- FIFO operation:
  - Pop happens when `out_valid`&`out_ready`.
  - Push happens when the FSM generates an event.
  - Push while full without a pop in the same cycle: the event is dropped and `overflow`←1.
  - Push and pop in the same cycle while full: both take effect, `count` is unchanged, and there is no overflow.
  - Push and pop in the same cycle while empty: impossible, because `out_valid`=0.
- Pointers are $clog2(DEPTH) bits and wrap naturally. `count` is tracked separately and its range is 0..DEPTH.
- `overflow` is cleared by `ovf_clr`=1. If a set and a clear happen in the same cycle, the set wins.

## Timing
- Reset values: FSM=IDLE, `cnt`=0, `cand`=0, pointers=0, `count`=0, `out_valid`=0, `out_code`=0, `overflow`=0. Reset has priority over all other inputs.
- A reset asserted mid-debounce or with a non-empty FIFO discards everything. There is no event on deassertion even if `gs` is held.
- Press latency: the first `gs`=1 sample is at edge E0. With `code` stable, the push occurs at edge E0+DEBOUNCE, and `out_valid`=1 in the cycle after that edge.
- No fall-through: data written to an empty FIFO is visible one cycle later.
- `out_code` is registered from the head entry and is stable while `out_valid`=1 and `out_ready`=0.
- Release needs DEBOUNCE+1 consecutive `gs`=0 samples, counting from the HELD→RELEASE edge, before a new press can start.
- `gs`/`code` are assumed synchronous to `clk`. The block has no synchronizer; that belongs upstream.

## Structure
- Shared package: FSM state enum (`ST_IDLE`, `ST_PRESS`, `ST_HELD`, `ST_RELEASE`) and the `CODE_W` default constant.
- One natural sub-module, `event_fifo`: a parameterized synchronous FIFO providing push, pop, full, empty and count.
- The detector FSM and the overflow flag live in the top level.
- The top level does not instantiate `encoder16_4`. The two are connected in the parent.

## Test plan
- Basic press: DEBOUNCE=4, `gs`=1 and `code`=4'hA for 10 cycles, `out_ready`=0 → exactly one entry, `out_code`=A, `count`=1, `out_valid` rises at E0+5.
- Bounce: `gs` pattern 1,1,0,1,1,1,1 with `code`=3 → the glitch restarts the debounce; a single push occurs 4 samples after the final rise.
- Code change: `code` 5,5,7,7,7,7 with `gs`=1 → event 7 only; a later change to 2 while in HELD produces no event.
- Full FIFO: DEPTH=4, five press/release cycles with `out_ready`=0 → `count`=4, `overflow`=1, head=first code; `ovf_clr` clears the flag.
- Full plus simultaneous pop: FIFO full, `out_ready`=1 in the same cycle as a push → `count` stays 4, `overflow` stays 0, order is preserved.
- Reset mid-operation: assert `rst_n`=0 during PRESS with 2 entries queued → all outputs return to reset values; no event after release of reset while `gs`=1, until `gs` drops and rises again.

Source files
------------

// File: rtl/priority_event_queue_pkg.sv
// Shared types and defaults for the debounced priority event queue.
package priority_event_queue_pkg;

   localparam int unsigned CODE_W_DEFAULT = 4;

   // Detector states: waiting, debouncing a press, latched, debouncing a release.
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESS,
      ST_HELD,
      ST_RELEASE
   } det_state_e;

endpackage

// File: rtl/priority_event_queue_if.sv
// Output handshake between the event queue and its consumer.
interface priority_event_queue_if
   import priority_event_queue_pkg::*;
#(
   parameter int unsigned CODE_W = CODE_W_DEFAULT
) ();

   logic [CODE_W-1:0] out_code;
   logic              out_valid;
   logic              out_ready;

   modport master (output out_code, output out_valid, input out_ready);
   modport slave  (input out_code, input out_valid, output out_ready);

endinterface

// File: rtl/event_fifo.sv
// Small synchronous FIFO; storage is reset so the head reads zero after reset.
module event_fifo #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   // A push into a full FIFO only lands if the head leaves in the same cycle.
   always_comb begin
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/priority_event_queue.sv
// Debounces the encoder's request and queues one event per press.
module priority_event_queue
   import priority_event_queue_pkg::*;
#(
   parameter int unsigned CODE_W   = CODE_W_DEFAULT,
   parameter int unsigned DEBOUNCE = 4,
   parameter int unsigned DEPTH    = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [CODE_W-1:0]       code,
   input  logic                    gs,
   priority_event_queue_if.master  out_if,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   input  logic                    ovf_clr
);

   localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

   det_state_e        state_q, state_d;
   logic [CODE_W-1:0] cand_q, cand_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              arm_q, arm_d;
   logic              ev_push;
   logic              overflow_q, overflow_d;
   logic              fifo_full, fifo_empty, fifo_pop;

   // Next-state logic of the press/release detector.
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      ev_push = 1'b0;
      // A request held through reset must drop once before it can count as a press.
      arm_d   = arm_q | ~gs;
      if (!en) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (gs && arm_q) begin
                  state_d = ST_PRESS;
                  cand_d  = code;
                  cnt_d   = '0;
               end
            end
            ST_PRESS: begin
               if (!gs) begin
                  state_d = ST_IDLE;
               end else if (code != cand_q) begin
                  cand_d = code;
                  cnt_d  = '0;
               end else if (cnt_q == CNT_LAST) begin
                  ev_push = 1'b1;
                  state_d = ST_HELD;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            ST_HELD: begin
               if (!gs) begin
                  state_d = ST_RELEASE;
                  cnt_d   = '0;
               end
            end
            ST_RELEASE: begin
               if (gs) begin
                  state_d = ST_HELD;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Detector state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cand_q  <= '0;
         cnt_q   <= '0;
         arm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         arm_q   <= arm_d;
      end
   end

   assign fifo_pop = out_if.out_valid && out_if.out_ready;

   event_fifo #(
      .WIDTH (CODE_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (ev_push),
      .pop   (fifo_pop),
      .wdata (cand_q),
      .rdata (out_if.out_code),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   assign out_if.out_valid = !fifo_empty;

   // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
   always_comb begin
      overflow_d = overflow_q;
      if (ev_push && fifo_full && !fifo_pop) begin
         overflow_d = 1'b1;
      end else if (ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   // Overflow flag register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign overflow = overflow_q;

endmodule

// File: tb/tb_priority_event_queue.sv
// Directed and randomized bench for priority_event_queue with a sample-history model.
module tb_priority_event_queue;

   localparam int unsigned CW    = 4;
   localparam int unsigned DEB   = 4;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n, en, gs, ovf_clr;
   logic [CW-1:0] code;
   logic [2:0]    count;
   logic          overflow;

   int checks   = 0;
   int failures = 0;

   // Reference model state: FIFO contents and run lengths of input samples.
   logic [CW-1:0] q[$];
   int            run_len;
   int            low_len;
   bit            latched;
   bit            seen_low;
   bit            m_ovf;
   logic [CW-1:0] last_code;

   priority_event_queue_if #(.CODE_W(CW)) bus ();

   priority_event_queue #(
      .CODE_W   (CW),
      .DEBOUNCE (DEB),
      .DEPTH    (DEPTH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .code     (code),
      .gs       (gs),
      .out_if   (bus),
      .count    (count),
      .overflow (overflow),
      .ovf_clr  (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Event when DEB+1 consecutive identical pressed samples are seen while unlatched;
   // unlatch after DEB+1 consecutive released samples.
   task automatic model_edge();
      bit ev, pop, set;
      if (!rst_n) begin
         q.delete();
         run_len  = 0;
         low_len  = 0;
         latched  = 0;
         seen_low = 0;
         m_ovf    = 0;
         return;
      end
      ev  = 0;
      pop = (q.size() > 0) && bus.out_ready;
      if (!en) begin
         latched = 0;
         run_len = 0;
         low_len = 0;
      end else if (latched) begin
         if (gs) begin
            low_len = 0;
         end else begin
            low_len++;
            if (low_len == DEB + 1) begin
               latched = 0;
               run_len = 0;
            end
         end
      end else begin
         if (!gs || !seen_low) begin
            run_len = 0;
         end else if (run_len > 0 && code == last_code) begin
            run_len++;
         end else begin
            run_len   = 1;
            last_code = code;
         end
         if (run_len == DEB + 1) begin
            ev      = 1;
            latched = 1;
            low_len = 0;
            run_len = 0;
         end
      end
      set = ev && (q.size() == DEPTH) && !pop;
      if (pop) void'(q.pop_front());
      if (ev && !set) q.push_back(last_code);
      if (set) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      if (!gs) seen_low = 1;
   endtask

   task automatic check_all();
      chk("valid", 32'(bus.out_valid), 32'(q.size() > 0));
      chk("count", 32'(count), 32'(q.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (q.size() > 0) chk("head", 32'(bus.out_code), 32'(q[0]));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic set_in(input bit g, input logic [CW-1:0] c, input bit rdy);
      gs            = g;
      code          = c;
      bus.out_ready = rdy;
   endtask

   task automatic run(input int n, input bit g, input logic [CW-1:0] c, input bit rdy);
      for (int i = 0; i < n; i++) begin
         set_in(g, c, rdy);
         cyc();
      end
   endtask

   initial begin
      bit bounce [10];
      logic [CW-1:0] chg [8];
      bounce = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 1};
      chg    = '{4'h5, 4'h5, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7};

      rst_n = 0; en = 1; ovf_clr = 0;
      set_in(0, '0, 0);
      run(2, 0, '0, 0);
      chk("rst_code", 32'(bus.out_code), 32'h0);
      chk("rst_valid", 32'(bus.out_valid), 32'h0);
      rst_n = 1;
      run(2, 0, '0, 0);

      // Basic press: valid appears in the sample after edge E0+DEB.
      for (int i = 0; i < 10; i++) begin
         set_in(1, 4'hA, 0);
         cyc();
         if (i == 3) chk("lat_early", 32'(bus.out_valid), 32'h0);
         if (i == 4) chk("lat_rise", 32'(bus.out_valid), 32'h1);
      end
      chk("basic_count", 32'(count), 32'h1);
      chk("basic_code", 32'(bus.out_code), 32'hA);
      run(6, 0, '0, 0);
      run(1, 0, '0, 1);
      chk("basic_drain", 32'(count), 32'h0);

      // Glitch restarts debounce; final rise at index 3, push at index 7.
      for (int i = 0; i < 10; i++) begin
         set_in(bounce[i], 4'h3, 0);
         cyc();
         if (i == 6) chk("bounce_early", 32'(bus.out_valid), 32'h0);
         if (i == 7) chk("bounce_push", 32'(bus.out_valid), 32'h1);
      end
      run(6, 0, '0, 0);
      run(1, 0, '0, 1);

      // Code change restarts; a change while held is ignored.
      for (int i = 0; i < 8; i++) begin
         set_in(1, chg[i], 0);
         cyc();
      end
      run(8, 1, 4'h2, 0);
      chk("chg_count", 32'(count), 32'h1);
      chk("chg_code", 32'(bus.out_code), 32'h7);
      run(6, 0, '0, 0);
      run(1, 0, '0, 1);

      // Five presses into a 4-deep FIFO.
      for (int k = 1; k <= 5; k++) begin
         run(6, 1, 4'(k), 0);
         run(6, 0, '0, 0);
      end
      chk("full_count", 32'(count), 32'h4);
      chk("full_ovf", 32'(overflow), 32'h1);
      chk("full_head", 32'(bus.out_code), 32'h1);
      ovf_clr = 1;
      run(1, 0, '0, 0);
      ovf_clr = 0;
      chk("ovf_clr", 32'(overflow), 32'h0);

      // Push and pop together while full.
      run(4, 1, 4'h9, 0);
      run(1, 1, 4'h9, 1);
      chk("fp_count", 32'(count), 32'h4);
      chk("fp_ovf", 32'(overflow), 32'h0);
      chk("fp_head", 32'(bus.out_code), 32'h2);
      run(3, 1, 4'h9, 0);
      run(6, 0, '0, 0);

      // Reset during a press with two entries queued.
      run(2, 0, '0, 1);
      chk("pre_rst_count", 32'(count), 32'h2);
      run(2, 1, 4'h6, 0);
      rst_n = 0;
      run(1, 1, 4'h6, 0);
      chk("rst_mid_count", 32'(count), 32'h0);
      chk("rst_mid_code", 32'(bus.out_code), 32'h0);
      rst_n = 1;
      run(10, 1, 4'h6, 0);
      chk("no_evt_after_rst", 32'(count), 32'h0);
      run(2, 0, '0, 0);
      run(6, 1, 4'h6, 0);
      chk("evt_after_rearm", 32'(count), 32'h1);
      chk("evt_after_rearm_code", 32'(bus.out_code), 32'h6);
      run(6, 0, '0, 1);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(5) == 0) gs = ~gs;
         if ($urandom_range(7) == 0) code = 4'($urandom);
         bus.out_ready = ($urandom_range(9) < 3);
         en            = ($urandom_range(49) != 0);
         ovf_clr       = ($urandom_range(19) == 0);
         rst_n         = ($urandom_range(299) != 0);
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
